// File: rtl/pokey_wr_sched.sv
// pokey_wr_sched: shares the POKEY register port between CPU and a paced write queue.
// Optional build macro POKEY_WR_SCHED_CPU_PRIO_EN: CPU always wins ties (else round-robin).

module pokey_wr_sched #(
  parameter int DEPTH = 8,
  parameter int GAP   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [3:0]              cpu_adr_i,
  input  logic [7:0]              cpu_dat_i,
  input  logic                    cpu_we_i,
  input  logic                    cpu_stb_i,
  output logic                    cpu_ack_o,
  output logic [7:0]              cpu_dat_o,
  input  logic [3:0]              q_adr_i,
  input  logic [7:0]              q_dat_i,
  input  logic                    q_valid_i,
  output logic                    q_ready_o,
  output logic [3:0]              pk_adr_o,
  output logic [7:0]              pk_dat_o,
  output logic                    pk_we_o,
  output logic                    pk_stb_o,
  input  logic [7:0]              pk_dat_i,
  output logic [$clog2(DEPTH):0]  q_level_o,
  output logic                    busy_o
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0]   lvl_t;
  typedef logic [AW-1:0] ptr_t;

  localparam lvl_t       FULL   = lvl_t'(DEPTH);
  localparam logic [3:0] GAP_LD = 4'(GAP);

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    QWR
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [3:0] adr_mem [DEPTH];
  logic [7:0] dat_mem [DEPTH];
  ptr_t       wr_q;
  ptr_t       rd_q;
  lvl_t       lvl_q;
  logic [3:0] gap_q;

  logic [3:0] adr_q;
  logic [7:0] dat_q;
  logic       we_q;

  logic       q_pend;
  logic       gnt_cpu;
  logic       gnt_q;
  logic       push;
  logic       pop;

  assign q_pend = (lvl_q != '0) && (gap_q == '0);

`ifdef POKEY_WR_SCHED_CPU_PRIO_EN
  assign gnt_cpu = cpu_stb_i;
`else
  // last_q=1 means the queue won the previous grant
  logic last_q;

  assign gnt_cpu = cpu_stb_i && (!q_pend || last_q);

  // remember who was granted last so ties alternate
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else if (state_q == IDLE) begin
      if (gnt_cpu) begin
        last_q <= 1'b0;
      end else if (q_pend) begin
        last_q <= 1'b1;
      end
    end
  end
`endif

  assign gnt_q = q_pend && !gnt_cpu;

  // next-state: bus cycles last one clock, then back to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_cpu) begin
          state_d = CPU;
        end else if (gnt_q) begin
          state_d = QWR;
        end
      end
      CPU:     state_d = IDLE;
      QWR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // capture the granted access; pk_adr/pk_dat hold it afterwards
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (gnt_cpu) begin
        adr_q <= cpu_adr_i;
        dat_q <= cpu_dat_i;
        we_q  <= cpu_we_i;
      end else if (gnt_q) begin
        adr_q <= adr_mem[rd_q];
        dat_q <= dat_mem[rd_q];
      end
    end
  end

  assign push = q_valid_i && q_ready_o;
  assign pop  = (state_q == QWR);

  // FIFO storage; contents are dropped by resetting the pointers
  always_ff @(posedge clk_i) begin
    if (push) begin
      adr_mem[wr_q] <= q_adr_i;
      dat_mem[wr_q] <= q_dat_i;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  // explicit occupancy so full and empty never alias
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lvl_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // pacing counter: reloaded by each queued write, counts down always
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gap_q <= '0;
    end else if (state_q == QWR) begin
      gap_q <= GAP_LD;
    end else if (gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end
  end

  assign q_ready_o = rst_n_i && (lvl_q != FULL);
  assign q_level_o = lvl_q;
  assign busy_o    = (lvl_q != '0) || (state_q != IDLE);

  assign cpu_ack_o = (state_q == CPU);
  assign cpu_dat_o = cpu_ack_o ? pk_dat_i : '0;

  assign pk_stb_o  = (state_q != IDLE);
  assign pk_we_o   = ((state_q == CPU) && we_q) || (state_q == QWR);
  assign pk_adr_o  = adr_q;
  assign pk_dat_o  = dat_q;

endmodule
